// File: rtl/cpu_pkg.sv
// Shared widths, writeback-select encodings and LSU state encoding for the 16-bit CPU.
// Pure declarations: no logic, no latency, no flow control.
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC2 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        DONE
    } lsu_state_t;
endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the memory-stage LSU (master) and memory (slave).
// Request side is registered by the master; ack is a single-cycle completion pulse.
interface mem_stage_lsu_if;
    import cpu_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues req/ack bus accesses and feeds MEM/WB.
// Latency: non-memory ops pass through in 0 cycles; memory ops stall (issue + wait) until ack/timeout.
module mem_stage_lsu #(
    parameter int DATA_W         = cpu_pkg::DATA_W,
    parameter int REG_W          = cpu_pkg::REG_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              regWrite_in,
    input  logic [1:0]        resultSrc_in,
    input  logic              memRead_in,
    input  logic              memWrite_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [DATA_W-1:0] aluRes_in,
    input  logic [DATA_W-1:0] writeData_in,
    mem_stage_lsu_if.master   bus,
    output logic              stall,
    output logic              regWrite_out,
    output logic [1:0]        resultSrc_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [DATA_W-1:0] aluRes_out,
    output logic [DATA_W-1:0] readData_out,
    output logic [DATA_W-1:0] writeDataM,
    output logic              bus_err
);
    import cpu_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err_kill;
    logic              mem_op;

    assign mem_op = valid_in & (memRead_in | memWrite_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            rdata_q       <= '0;
            cnt           <= '0;
            bus_err       <= 1'b0;
            err_kill      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= memWrite_in;   // write wins when both are set
                        bus.mem_addr  <= aluRes_in;
                        bus.mem_wdata <= writeData_in;
                        cnt           <= '0;
                        state         <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (bus.mem_ack) begin
                        if (!bus.mem_we) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        bus.mem_req <= 1'b0;
                        cnt         <= '0;
                        state       <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus.mem_req <= 1'b0;
                        bus_err     <= 1'b1;
                        rdata_q     <= '0;
                        err_kill    <= 1'b1;
                        cnt         <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    err_kill <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data outputs always follow the inputs; only the control fields are squashed for a bubble.
    always_comb begin
        stall         = 1'b0;
        regWrite_out  = regWrite_in & valid_in;
        resultSrc_out = resultSrc_in;
        rd_out        = rd_in;
        aluRes_out    = aluRes_in;
        readData_out  = rdata_q;
        writeDataM    = writeData_in;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall         = 1'b1;
                    regWrite_out  = 1'b0;
                    resultSrc_out = 2'b00;
                    rd_out        = '0;
                end
            end
            WAIT_ACK: begin
                stall         = 1'b1;
                regWrite_out  = 1'b0;
                resultSrc_out = 2'b00;
                rd_out        = '0;
            end
            DONE: begin
                regWrite_out = regWrite_in & ~err_kill;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a transaction-level timing/data model.
// Each instruction is driven, its stall/bus/writeback behaviour predicted from the ack delay.
module tb_mem_stage_lsu;
    import cpu_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, regWrite_in, memRead_in, memWrite_in;
    logic [1:0]  resultSrc_in;
    logic [3:0]  rd_in;
    logic [15:0] aluRes_in, writeData_in;
    logic        stall, regWrite_out, bus_err;
    logic [1:0]  resultSrc_out;
    logic [3:0]  rd_out;
    logic [15:0] aluRes_out, readData_out, writeDataM;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_rdata;
    logic        exp_err;

    always #5 clk = ~clk;

    mem_stage_lsu_if bus_if ();

    mem_stage_lsu #(.DATA_W(16), .REG_W(4), .TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .regWrite_in  (regWrite_in),
        .resultSrc_in (resultSrc_in),
        .memRead_in   (memRead_in),
        .memWrite_in  (memWrite_in),
        .rd_in        (rd_in),
        .aluRes_in    (aluRes_in),
        .writeData_in (writeData_in),
        .bus          (bus_if.master),
        .stall        (stall),
        .regWrite_out (regWrite_out),
        .resultSrc_out(resultSrc_out),
        .rd_out       (rd_out),
        .aluRes_out   (aluRes_out),
        .readData_out (readData_out),
        .writeDataM   (writeDataM),
        .bus_err      (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one instruction and checks every cycle it occupies.
    // ack_dly = index of the wait cycle carrying mem_ack, or -1 for never.
    task automatic run_instr(input logic v, input logic rw, input logic [1:0] rs,
                             input logic mr, input logic mw, input logic [3:0] rd,
                             input logic [15:0] alu, input logic [15:0] wd,
                             input int ack_dly, input logic [15:0] rdata);
        logic is_mem;
        logic timed_out;
        bit   finished;
        int   k;
        valid_in = v; regWrite_in = rw; resultSrc_in = rs; memRead_in = mr;
        memWrite_in = mw; rd_in = rd; aluRes_in = alu; writeData_in = wd;
        is_mem = v & (mr | mw);
        if (!is_mem) begin
            @(negedge clk);
            chk("pass_stall", 32'(stall), 32'd0);
            chk("pass_regw", 32'(regWrite_out), 32'(rw & v));
            chk("pass_rd", 32'(rd_out), 32'(rd));
            chk("pass_rs", 32'(resultSrc_out), 32'(rs));
            chk("pass_alu", 32'(aluRes_out), 32'(alu));
            chk("pass_wdm", 32'(writeDataM), 32'(wd));
            chk("pass_rdata", 32'(readData_out), 32'(exp_rdata));
            chk("pass_req", 32'(bus_if.mem_req), 32'd0);
            chk("pass_err", 32'(bus_err), 32'(exp_err));
            @(posedge clk); #1;
            return;
        end
        @(negedge clk);
        chk("issue_stall", 32'(stall), 32'd1);
        chk("issue_bubble", {29'd0, regWrite_out, resultSrc_out}, 32'd0);
        chk("issue_rd", 32'(rd_out), 32'd0);
        chk("issue_req", 32'(bus_if.mem_req), 32'd0);
        @(posedge clk); #1;
        k = 0; finished = 0; timed_out = 0;
        while (!finished) begin
            if (k == ack_dly) begin
                bus_if.mem_ack = 1'b1;
                bus_if.mem_rdata = rdata;
            end
            @(negedge clk);
            chk("wait_stall", 32'(stall), 32'd1);
            chk("wait_req", 32'(bus_if.mem_req), 32'd1);
            chk("wait_we", 32'(bus_if.mem_we), 32'(mw));
            chk("wait_addr", 32'(bus_if.mem_addr), 32'(alu));
            chk("wait_wdata", 32'(bus_if.mem_wdata), 32'(wd));
            chk("wait_regw", 32'(regWrite_out), 32'd0);
            @(posedge clk); #1;
            bus_if.mem_ack = 1'b0;
            bus_if.mem_rdata = 16'($urandom);
            if (k == ack_dly) finished = 1;
            else if (k == T - 1) begin finished = 1; timed_out = 1; end
            k++;
        end
        if (timed_out) begin
            exp_err = 1'b1;
            exp_rdata = 16'h0000;
        end else if (!mw) begin
            exp_rdata = rdata;
        end
        @(negedge clk);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req", 32'(bus_if.mem_req), 32'd0);
        chk("done_regw", 32'(regWrite_out), 32'(rw & ~timed_out));
        chk("done_rd", 32'(rd_out), 32'(rd));
        chk("done_rs", 32'(resultSrc_out), 32'(rs));
        chk("done_rdata", 32'(readData_out), 32'(exp_rdata));
        chk("done_err", 32'(bus_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; valid_in = 0; regWrite_in = 0; resultSrc_in = 0; memRead_in = 0;
        memWrite_in = 0; rd_in = 0; aluRes_in = 0; writeData_in = 0;
        bus_if.mem_ack = 0; bus_if.mem_rdata = 0;
        exp_rdata = 0; exp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", 32'(bus_if.mem_req), 32'd0);
        chk("rst_we", 32'(bus_if.mem_we), 32'd0);
        chk("rst_addr", 32'(bus_if.mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus_if.mem_wdata), 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        chk("rst_rdata", 32'(readData_out), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(1, 1, RES_ALU, 0, 0, 4'd3, 16'h0042, 16'h0000, 0, 16'h0);
        run_instr(1, 1, RES_MEM, 1, 0, 4'd5, 16'h0100, 16'h0000, 0, 16'hBEEF);
        run_instr(1, 0, RES_ALU, 0, 1, 4'd0, 16'h0200, 16'h1234, 2, 16'h0);
        run_instr(1, 1, RES_MEM, 1, 0, 4'd6, 16'h0010, 16'h0000, 0, 16'h0A0A);
        run_instr(1, 1, RES_MEM, 1, 0, 4'd7, 16'h0012, 16'h0000, 0, 16'h0B0B);
        run_instr(1, 1, RES_MEM, 1, 1, 4'd8, 16'h0020, 16'h5A5A, 1, 16'h7777);
        run_instr(1, 1, RES_MEM, 1, 0, 4'd9, 16'h0400, 16'h0000, -1, 16'h0);
        run_instr(1, 1, RES_PC2, 0, 0, 4'd1, 16'h0002, 16'h0000, 0, 16'h0);

        // Reset lands during the second wait cycle; the ack that follows must be ignored.
        valid_in = 1; regWrite_in = 1; resultSrc_in = RES_MEM; memRead_in = 1; memWrite_in = 0;
        rd_in = 4'd2; aluRes_in = 16'h0300; writeData_in = 0;
        @(negedge clk);
        chk("rw_issue_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_wait1_req", 32'(bus_if.mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; valid_in = 0;
        @(negedge clk);
        chk("rw_wait2_req", 32'(bus_if.mem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 16'hDEAD;
        @(negedge clk);
        chk("rw_post_req", 32'(bus_if.mem_req), 32'd0);
        chk("rw_post_stall", 32'(stall), 32'd0);
        chk("rw_post_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        bus_if.mem_ack = 1'b0;
        @(negedge clk);
        chk("rw_late_req", 32'(bus_if.mem_req), 32'd0);
        chk("rw_late_stall", 32'(stall), 32'd0);
        chk("rw_late_rdata", 32'(readData_out), 32'd0);
        @(posedge clk); #1;
        exp_rdata = 16'h0000; exp_err = 1'b0;

        for (int i = 0; i < 150; i++) begin
            int kind, dly;
            logic v, mr, mw;
            kind = $urandom_range(0, 3);
            v = 1'b1; mr = 1'b0; mw = 1'b0;
            case (kind)
                0: begin v = 1'($urandom_range(0, 1)); mr = ~v & 1'($urandom_range(0, 1)); end
                1: mr = 1'b1;
                2: mw = 1'b1;
                default: begin mr = 1'b1; mw = 1'b1; end
            endcase
            if ($urandom_range(0, 19) == 0) dly = -1;
            else dly = $urandom_range(0, T - 1);
            run_instr(v, 1'($urandom), 2'($urandom_range(0, 2)), mr, mw, 4'($urandom),
                      16'($urandom), 16'($urandom), dly, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
